// File: rtl/output_layer_sequencer_if.sv
// Bundle of config, input-vector, neuron and result signals of the output-layer sequencer.
interface output_layer_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [4:0]       cfg_wdata;
  logic             cfg_busy;

  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_d0;
  logic [11:0]      in_d1;
  logic [11:0]      in_d2;
  logic [11:0]      in_d3;

  logic [4:0]       w48;
  logic [4:0]       w58;
  logic [4:0]       w68;
  logic [4:0]       w78;
  logic [4:0]       w49;
  logic [4:0]       w59;
  logic [4:0]       w69;
  logic [4:0]       w79;

  logic [11:0]      nrn_in0;
  logic [11:0]      nrn_in1;
  logic [11:0]      nrn_in2;
  logic [11:0]      nrn_in3;
  logic             nrn_start;
  logic [16:0]      nrn_out0;
  logic [16:0]      nrn_out1;
  logic             nrn_rdy0;
  logic             nrn_rdy1;

  logic             res_valid;
  logic             res_ready;
  logic [16:0]      res_out0;
  logic [16:0]      res_out1;
  logic             res_class;
  logic             timeout_err;
  logic [CNT_W-1:0] sample_count;

  // Sequencer side
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_busy,
    input  in_valid, in_d0, in_d1, in_d2, in_d3,
    output in_ready,
    output w48, w58, w68, w78, w49, w59, w69, w79,
    output nrn_in0, nrn_in1, nrn_in2, nrn_in3, nrn_start,
    input  nrn_out0, nrn_out1, nrn_rdy0, nrn_rdy1,
    output res_valid, res_out0, res_out1, res_class, timeout_err, sample_count,
    input  res_ready
  );

  // Environment side: upstream, config host, output layer and result consumer
  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_busy,
    output in_valid, in_d0, in_d1, in_d2, in_d3,
    input  in_ready,
    input  w48, w58, w68, w78, w49, w59, w69, w79,
    input  nrn_in0, nrn_in1, nrn_in2, nrn_in3, nrn_start,
    output nrn_out0, nrn_out1, nrn_rdy0, nrn_rdy1,
    input  res_valid, res_out0, res_out1, res_class, timeout_err, sample_count,
    output res_ready
  );
endinterface

// File: rtl/output_layer_sequencer.sv
// Sequences one pass of the two-neuron output layer: weight config, vector issue,
// result collection with timeout, and argmax result delivery over valid/ready.
module output_layer_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output_layer_sequencer_if.slave  bus
);

  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [4:0]       r_w [8];
  logic [11:0]      r_nrn_in0;
  logic [11:0]      r_nrn_in1;
  logic [11:0]      r_nrn_in2;
  logic [11:0]      r_nrn_in3;
  logic             r_nrn_start;
  logic             r_cfg_busy;
  logic             r_res_valid;
  logic [16:0]      r_res_out0;
  logic [16:0]      r_res_out1;
  logic             r_res_class;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_sample_count;
  logic             r_done0;
  logic             r_done1;
  logic [TMR_W-1:0] r_timer;

  logic             w_accept;
  logic             w_in_ready;
  logic             w_timeout_hit;
  logic             w_done0_nxt;
  logic             w_done1_nxt;
  logic [16:0]      w_res0_nxt;
  logic [16:0]      w_res1_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, handshake and result-capture decode
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_in_ready    = 1'b0;
    w_timeout_hit = 1'b0;
    w_done0_nxt   = r_done0;
    w_done1_nxt   = r_done1;
    w_res0_nxt    = r_res_out0;
    w_res1_nxt    = r_res_out1;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.nrn_rdy0) begin
          w_done0_nxt = 1'b1;
          w_res0_nxt  = bus.nrn_out0;
        end
        if (bus.nrn_rdy1) begin
          w_done1_nxt = 1'b1;
          w_res1_nxt  = bus.nrn_out1;
        end
        if (w_done0_nxt && w_done1_nxt) begin
          w_state_nxt = OUT;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_timeout_hit = 1'b1;
          if (!w_done0_nxt) w_res0_nxt = 17'd0;
          if (!w_done1_nxt) w_res1_nxt = 17'd0;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        // Ready passes straight through so a result handshake and the next
        // accept share a cycle.
        w_in_ready = bus.res_ready;
        if (bus.res_ready) begin
          if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nrn_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_cfg_busy  <= 1'b0;
    end else begin
      r_nrn_start <= (w_state_nxt == ISSUE);
      r_res_valid <= (w_state_nxt == OUT);
      r_cfg_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Weight register file, writable only while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_w[i] <= 5'd0;
    end else if ((r_state == IDLE) && bus.cfg_we) begin
      r_w[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  // Activation latch on vector accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nrn_in0 <= 12'd0;
      r_nrn_in1 <= 12'd0;
      r_nrn_in2 <= 12'd0;
      r_nrn_in3 <= 12'd0;
    end else if (w_accept) begin
      r_nrn_in0 <= bus.in_d0;
      r_nrn_in1 <= bus.in_d1;
      r_nrn_in2 <= bus.in_d2;
      r_nrn_in3 <= bus.in_d3;
    end
  end

  // Done flags and WAIT timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_timer <= '0;
    end else if (r_state == ISSUE) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_timer <= '0;
    end else if (r_state == WAIT) begin
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Result capture and argmax, frozen outside WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_out0  <= 17'd0;
      r_res_out1  <= 17'd0;
      r_res_class <= 1'b0;
    end else if (r_state == WAIT) begin
      r_res_out0 <= w_res0_nxt;
      r_res_out1 <= w_res1_nxt;
      if (w_state_nxt == OUT) r_res_class <= ($signed(w_res1_nxt) > $signed(w_res0_nxt));
    end
  end

  // Sticky timeout flag and completed-sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err  <= 1'b0;
      r_sample_count <= '0;
    end else begin
      if (w_timeout_hit) r_timeout_err <= 1'b1;
      if ((r_state == OUT) && bus.res_ready) r_sample_count <= r_sample_count + CNT_W'(1);
    end
  end

  assign bus.cfg_busy     = r_cfg_busy;
  assign bus.in_ready     = w_in_ready;
  assign bus.w48          = r_w[0];
  assign bus.w58          = r_w[1];
  assign bus.w68          = r_w[2];
  assign bus.w78          = r_w[3];
  assign bus.w49          = r_w[4];
  assign bus.w59          = r_w[5];
  assign bus.w69          = r_w[6];
  assign bus.w79          = r_w[7];
  assign bus.nrn_in0      = r_nrn_in0;
  assign bus.nrn_in1      = r_nrn_in1;
  assign bus.nrn_in2      = r_nrn_in2;
  assign bus.nrn_in3      = r_nrn_in3;
  assign bus.nrn_start    = r_nrn_start;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_out0     = r_res_out0;
  assign bus.res_out1     = r_res_out1;
  assign bus.res_class    = r_res_class;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.sample_count = r_sample_count;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Directed self-checking bench for output_layer_sequencer.
module tb_output_layer_sequencer;

  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  output_layer_sequencer_if #(.CNT_W(16)) bus ();

  output_layer_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector in IDLE and take the accept edge; ends in the ISSUE cycle
  task automatic accept(input logic [11:0] d0, input logic [11:0] d1,
                        input logic [11:0] d2, input logic [11:0] d3);
    bus.in_valid = 1'b1;
    bus.in_d0 = d0; bus.in_d1 = d1; bus.in_d2 = d2; bus.in_d3 = d3;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("issue_nrn_in0", 32'(bus.nrn_in0), 32'(d0));
    chk("issue_nrn_in3", 32'(bus.nrn_in3), 32'(d3));
  endtask

  // From ISSUE, pulse rdy0 at WAIT cycle k0 and rdy1 at k1 (0 = never); ends in OUT
  task automatic wait_phase(input int k0, input int k1,
                            input logic [16:0] o0, input logic [16:0] o1);
    bit got0;
    bit got1;
    got0 = 1'b0;
    got1 = 1'b0;
    chk("start_high", 32'(bus.nrn_start), 32'd1);
    chk("busy_issue", 32'(bus.cfg_busy), 32'd1);
    bus.nrn_out0 = o0;
    bus.nrn_out1 = o1;
    tick();
    chk("start_one_cycle", 32'(bus.nrn_start), 32'd0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      bus.nrn_rdy0 = (k == k0);
      bus.nrn_rdy1 = (k == k1);
      if (k == k0) got0 = 1'b1;
      if (k == k1) got1 = 1'b1;
      chk("wait_no_valid", 32'(bus.res_valid), 32'd0);
      tick();
      if (got0 && got1) break;
    end
    bus.nrn_rdy0 = 1'b0;
    bus.nrn_rdy1 = 1'b0;
    chk("out_res_valid", 32'(bus.res_valid), 32'd1);
  endtask

  // Complete the result handshake with no follow-on vector
  task automatic release_res(input int exp_count);
    bus.res_ready = 1'b1;
    #1;
    chk("out_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.res_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.res_valid), 32'd0);
    chk("post_hs_busy", 32'(bus.cfg_busy), 32'd0);
    chk("sample_count", 32'(bus.sample_count), 32'(exp_count));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 5'd0;
    bus.in_valid = 1'b0;
    bus.in_d0 = 12'd0; bus.in_d1 = 12'd0; bus.in_d2 = 12'd0; bus.in_d3 = 12'd0;
    bus.nrn_out0 = 17'd0; bus.nrn_out1 = 17'd0;
    bus.nrn_rdy0 = 1'b0; bus.nrn_rdy1 = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.cfg_busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_nrn_start", 32'(bus.nrn_start), 32'd0);
    chk("rst_count", 32'(bus.sample_count), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_w48", 32'(bus.w48), 32'd0);

    // Config writes in IDLE
    for (int i = 0; i < 8; i++) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'(i);
      bus.cfg_wdata = (i < 4) ? 5'd1 : 5'd2;
      tick();
    end
    bus.cfg_we = 1'b0;
    chk("cfg_w48", 32'(bus.w48), 32'd1);
    chk("cfg_w78", 32'(bus.w78), 32'd1);
    chk("cfg_w49", 32'(bus.w49), 32'd2);
    chk("cfg_w79", 32'(bus.w79), 32'd2);

    // Pass 1: latency 3, out0=10 out1=20
    accept(12'h011, 12'h022, 12'h033, 12'h044);
    wait_phase(3, 3, 17'd10, 17'd20);
    chk("p1_out0", 32'(bus.res_out0), 32'd10);
    chk("p1_out1", 32'(bus.res_out1), 32'd20);
    chk("p1_class", 32'(bus.res_class), 32'd1);
    chk("p1_timeout", 32'(bus.timeout_err), 32'd0);
    release_res(1);

    // Pass 2: skewed ready, tie at -5
    accept(12'hFFF, 12'h800, 12'h7FF, 12'h001);
    wait_phase(1, 4, 17'h1FFFB, 17'h1FFFB);
    chk("p2_out0", 32'(bus.res_out0), 32'h1FFFB);
    chk("p2_out1", 32'(bus.res_out1), 32'h1FFFB);
    chk("p2_class_tie", 32'(bus.res_class), 32'd0);
    release_res(2);

    // Pass 3: simultaneous ready, out0=3 out1=-4 (signed compare)
    accept(12'h100, 12'h200, 12'h300, 12'h400);
    wait_phase(2, 2, 17'd3, 17'h1FFFC);
    chk("p3_out0", 32'(bus.res_out0), 32'd3);
    chk("p3_out1", 32'(bus.res_out1), 32'h1FFFC);
    chk("p3_class", 32'(bus.res_class), 32'd0);
    release_res(3);

    // Pass 4: rdy1 never arrives, out0=-7 -> timeout, out1 forced 0
    accept(12'h005, 12'h006, 12'h007, 12'h008);
    wait_phase(2, 0, 17'h1FFF9, 17'd99);
    chk("p4_timeout", 32'(bus.timeout_err), 32'd1);
    chk("p4_out0", 32'(bus.res_out0), 32'h1FFF9);
    chk("p4_out1_forced", 32'(bus.res_out1), 32'd0);
    chk("p4_class", 32'(bus.res_class), 32'd1);
    release_res(4);

    // Pass 5: good pass, sticky timeout, then backpressure with a queued vector
    accept(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD);
    wait_phase(1, 1, 17'd1, 17'd2);
    chk("p5_timeout_sticky", 32'(bus.timeout_err), 32'd1);
    chk("p5_class", 32'(bus.res_class), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_d0 = 12'h123; bus.in_d1 = 12'h456; bus.in_d2 = 12'h789; bus.in_d3 = 12'hABC;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_out1", 32'(bus.res_out1), 32'd2);
      chk("bp_count", 32'(bus.sample_count), 32'd4);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.res_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("b2b_issue", 32'(bus.nrn_start), 32'd1);
    chk("b2b_valid_low", 32'(bus.res_valid), 32'd0);
    chk("b2b_nrn_in0", 32'(bus.nrn_in0), 32'h123);
    chk("b2b_nrn_in2", 32'(bus.nrn_in2), 32'h789);
    chk("b2b_count", 32'(bus.sample_count), 32'd5);

    // Pass 6: busy config drop, then reset during WAIT
    tick();
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 5'd7;
    tick();
    bus.cfg_we = 1'b0;
    chk("busy_wait", 32'(bus.cfg_busy), 32'd1);
    chk("busy_w48_kept", 32'(bus.w48), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.cfg_busy), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_w48", 32'(bus.w48), 32'd0);
    chk("mrst_nrn_in0", 32'(bus.nrn_in0), 32'd0);
    chk("mrst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("mrst_count", 32'(bus.sample_count), 32'd0);
    chk("mrst_out0", 32'(bus.res_out0), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.nrn_rdy0 = 1'b1;
    bus.nrn_out0 = 17'd55;
    tick();
    bus.nrn_rdy0 = 1'b0;
    tick();
    chk("late_rdy_out0", 32'(bus.res_out0), 32'd0);
    chk("late_rdy_valid", 32'(bus.res_valid), 32'd0);
    chk("late_rdy_busy", 32'(bus.cfg_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_layer_sequencer.md
Name: output_layer_sequencer

Overview:
- Controls one pass of the two-neuron 17-bit output layer for the ECE 755 DNN.
- Holds the eight 5-bit output-layer weights in a config register file.
- Accepts one 4-element hidden-layer vector per transaction over valid/ready.
- Pulses the layer start, waits for both neuron results with a timeout, then presents out0/out1 plus an argmax class to the downstream consumer over valid/ready.

Parameters:
TIMEOUT  15  number of WAIT cycles allowed for both results before abort (≥1)
CNT_W  16  width of the completed-sample counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  weight write strobe
cfg_addr  in  3  0..3 → w48,w58,w68,w78; 4..7 → w49,w59,w69,w79
cfg_wdata  in  5  signed weight value
cfg_busy  out  1  high when state≠IDLE; writes are ignored while high
in_valid  in  1  upstream vector valid
in_ready  out  1  sequencer can accept a vector
in_d0..in_d3  in  12 each  signed hidden-layer activations
w48,w58,w68,w78,w49,w59,w69,w79  out  5 each  registered weights to output layer
nrn_in0..nrn_in3  out  12 each  registered activations to output layer
nrn_start  out  1  one-cycle input_ready pulse to output layer
nrn_out0, nrn_out1  in  17 each  signed neuron results
nrn_rdy0, nrn_rdy1  in  1 each  neuron result-ready pulses
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_out0, res_out1  out  17 each  captured results
res_class  out  1  argmax: 1 iff res_out1 > res_out0 (signed); tie → 0
timeout_err  out  1  sticky abort flag
sample_count  out  CNT_W  completed result handshakes, wraps to 0

Behaviour:
- Reset values (async, active-high):
  - State IDLE.
  - All weights, nrn_in*, res_out*, res_class, sample_count, and timeout_err = 0.
  - nrn_start=0, res_valid=0.
  - Reset mid-operation aborts immediately. A neuron pulse arriving after reset is ignored.
- FSM states IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_d0..3 into nrn_in0..3 and go to ISSUE.
  - cfg_we in IDLE writes cfg_wdata to the addressed weight that cycle.
  - If cfg_we and in_valid coincide, both take effect; the new weight is visible from ISSUE onward.
- ISSUE:
  - nrn_start=1 for exactly this cycle.
  - Clear done0/done1 flags and the timer. Go to WAIT.
- WAIT:
  - nrn_rdyX sets sticky doneX and captures nrn_outX into res_outX the same edge.
  - The two pulses may arrive on the same or different cycles, in either order.
  - The timer increments each WAIT cycle.
  - When done0&done1 (including the cycle the second pulse arrives), go to OUT.
  - If the timer reaches TIMEOUT with either flag clear:
    - Set timeout_err.
    - Missing results are forced to 0.
    - Go to OUT. The result is still delivered.
- OUT:
  - res_valid=1. res_class is registered on OUT entry from the final res_out values.
  - Outputs are held stable until res_ready.
  - On res_valid&res_ready: sample_count++ (wraps at 2^CNT_W).
  - in_ready = res_ready while in OUT.
  - If in_valid also high: latch the new vector and go directly to ISSUE (back-to-back, no IDLE bubble). Otherwise go to IDLE.
- nrn_rdy* outside WAIT is ignored. A duplicate pulse in WAIT recaptures that result.
- cfg_we while cfg_busy is dropped; weights stay constant for the whole pass.
- timeout_err is cleared only by reset.
- Latency (neuron latency L ≤ TIMEOUT): accept edge → ISSUE 1 cycle → WAIT L cycles → res_valid on the cycle after the second pulse edge.

Test Plan:
- Config write then pass: write w48..w78=1 and w49..w79=2 in IDLE; bench neuron model latency 3 returns out0=10, out1=20 → nrn_start is a single 1-cycle pulse; res_valid 5 cycles after accept; res_out0=10, res_out1=20, res_class=1, sample_count=1.
- Skewed/simultaneous ready: rdy0 at WAIT cycle 1 and rdy1 at cycle 4, then a pass with both on the same cycle; out0=-5, out1=-5 → OUT entered only after both; res_class=0 (tie).
- Timeout: rdy1 never asserts, TIMEOUT=15 → after 15 WAIT cycles timeout_err=1, res_out1=0, res_out0 captured; timeout_err stays high through following good passes.
- Backpressure and back-to-back: hold res_ready=0 for 6 cycles with in_valid=1 → results stable, in_ready=0; release → same-cycle accept of next vector, ISSUE next cycle; sample_count increments once per handshake.
- Busy config drop and reset mid-WAIT: cfg_we w48=7 during WAIT → w48 unchanged; assert rst during WAIT → all outputs zero, state IDLE; late nrn_rdy0 after reset → no effect.
